// File: rtl/npc_trace_pkg.sv
// Shared types for the commit trace path: the per-instruction commit record
// and the ebreak encoding that stops simulation.
package npc_trace_pkg;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic [4:0]  rd;
      logic        wen;
      logic [63:0] wdata;
      logic        skip;
      logic [63:0] seq;
   } commit_rec_t;

   localparam int REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; the head entry is read
// combinationally so a record is visible the cycle after it is written.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push_en,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop_en,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                    (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
   assign do_push = push_en && !full;
   assign do_pop  = pop_en && !empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
   end

   // Storage needs no reset: it is only observable through a non-empty head.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/commit_trace_queue.sv
// Queues retired instructions for the DPI trace bridge, tagging each with a
// retire sequence number, halting on ebreak and flagging a retire hang.
module commit_trace_queue
   import npc_trace_pkg::*;
#(
   parameter int          DEPTH   = 4,
   parameter int unsigned TIMEOUT = 10000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [63:0] wb_pc,
   input  logic [31:0] wb_inst,
   input  logic [4:0]  wb_rd,
   input  logic        wb_wen,
   input  logic [63:0] wb_wdata,
   input  logic        wb_skip,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_inst,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   output logic [63:0] out_wdata,
   output logic        out_skip,
   output logic [63:0] out_seq,
   output logic [63:0] instret,
   output logic        halt,
   output logic        hang
);

   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

   commit_rec_t push_rec;
   commit_rec_t head_rec;
   logic        fifo_full;
   logic        fifo_empty;
   logic        accept;
   logic [63:0] instret_reg;
   logic        halt_reg;
   logic        hang_reg;
   logic [31:0] idle_reg;
   logic [31:0] idle_next;

   // Ready depends only on registered state, never on out_ready.
   assign wb_ready = !fifo_full && !halt_reg;
   assign accept   = wb_valid && wb_ready;

   always_comb begin
      push_rec       = '0;
      push_rec.pc    = wb_pc;
      push_rec.inst  = wb_inst;
      push_rec.rd    = wb_rd;
      push_rec.wen   = wb_wen;
      push_rec.wdata = wb_wdata;
      push_rec.skip  = wb_skip;
      push_rec.seq   = instret_reg;
   end

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push_en   (accept),
      .push_data (push_rec),
      .full      (fifo_full),
      .pop_en    (out_ready),
      .empty     (fifo_empty),
      .head_data (head_rec)
   );

   // Idle counter freezes once halted and saturates at the timeout.
   always_comb begin
      idle_next = idle_reg;
      if (accept)
         idle_next = '0;
      else if (!halt_reg && idle_reg < TIMEOUT_W)
         idle_next = idle_reg + 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instret_reg <= '0;
         halt_reg    <= 1'b0;
         hang_reg    <= 1'b0;
         idle_reg    <= '0;
      end else begin
         if (accept) instret_reg <= instret_reg + 64'd1;
         if (accept && wb_inst == INST_EBREAK) halt_reg <= 1'b1;
         if (idle_next >= TIMEOUT_W) hang_reg <= 1'b1;
         idle_reg <= idle_next;
      end
   end

   assign out_valid = !fifo_empty;
   assign out_pc    = head_rec.pc;
   assign out_inst  = head_rec.inst;
   assign out_rd    = head_rec.rd;
   assign out_wen   = head_rec.wen;
   assign out_wdata = head_rec.wdata;
   assign out_skip  = head_rec.skip;
   assign out_seq   = head_rec.seq;
   assign instret   = instret_reg;
   assign halt      = halt_reg;
   assign hang      = hang_reg;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Randomised and directed bench for commit_trace_queue, checked every cycle
// against a queue-based model of the retire/trace rules.
module tb_commit_trace_queue;
   import npc_trace_pkg::*;

   localparam int          DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic [63:0] wb_pc = '0;
   logic [31:0] wb_inst = 32'h13;
   logic [4:0]  wb_rd = '0;
   logic        wb_wen = 1'b0;
   logic [63:0] wb_wdata = '0;
   logic        wb_skip = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic [63:0] out_wdata;
   logic        out_skip;
   logic [63:0] out_seq;
   logic [63:0] instret;
   logic        halt;
   logic        hang;

   int checks = 0;
   int passes = 0;
   bit check_en = 1'b0;

   // Behavioural model state
   commit_rec_t m_q[$];
   longint unsigned m_instret = 0;
   bit m_halt = 1'b0;
   bit m_hang = 1'b0;
   int unsigned m_idle = 0;
   bit m_pop, m_acc;
   commit_rec_t m_r;

   commit_trace_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset_n(reset_n),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_rd(wb_rd), .wb_wen(wb_wen),
      .wb_wdata(wb_wdata), .wb_skip(wb_skip),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_rd(out_rd), .out_wen(out_wen),
      .out_wdata(out_wdata), .out_skip(out_skip), .out_seq(out_seq),
      .instret(instret), .halt(halt), .hang(hang)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s act=%h exp=%h", name, act, exp);
   endtask

   always @(negedge reset_n) begin
      m_q.delete();
      m_instret = 0;
      m_halt = 1'b0;
      m_hang = 1'b0;
      m_idle = 0;
   end

   always @(posedge clock) begin
      if (reset_n) begin
         m_pop = (m_q.size() != 0) && out_ready;
         m_acc = wb_valid && (m_q.size() < DEPTH) && !m_halt;
         if (m_pop) void'(m_q.pop_front());
         if (m_acc) begin
            m_r.pc = wb_pc; m_r.inst = wb_inst; m_r.rd = wb_rd; m_r.wen = wb_wen;
            m_r.wdata = wb_wdata; m_r.skip = wb_skip; m_r.seq = m_instret;
            m_q.push_back(m_r);
            m_instret++;
            if (wb_inst == INST_EBREAK) m_halt = 1'b1;
            m_idle = 0;
         end else if (!m_halt && m_idle < TIMEOUT) begin
            m_idle++;
         end
         if (m_idle >= TIMEOUT) m_hang = 1'b1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (check_en) begin
         commit_rec_t act;
         chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
         chk("wb_ready", 64'(wb_ready), 64'((m_q.size() < DEPTH) && !m_halt));
         chk("instret", instret, m_instret);
         chk("halt", 64'(halt), 64'(m_halt));
         chk("hang", 64'(hang), 64'(m_hang));
         if (m_q.size() != 0) begin
            act.pc = out_pc; act.inst = out_inst; act.rd = out_rd; act.wen = out_wen;
            act.wdata = out_wdata; act.skip = out_skip; act.seq = out_seq;
            checks++;
            if (act === m_q[0]) passes++;
            else $display("FAIL head_rec act=%h exp=%h", act, m_q[0]);
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic push(input logic [63:0] pc, input logic [31:0] inst);
      wb_valid = 1'b1; wb_pc = pc; wb_inst = inst;
      wb_rd = 5'($urandom); wb_wen = 1'($urandom); wb_skip = 1'($urandom);
      wb_wdata = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_wb_ready", 64'(wb_ready), 64'd1);
      chk("rst_instret", instret, 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_hang", 64'(hang), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      #4;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [63:0] prev;
      logic [31:0] inst;
      bit found;
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_wb_ready", 64'(wb_ready), 64'd1);
      chk("rst_instret", instret, 64'd0);
      chk("rst_out_seq", out_seq, 64'd0);
      #10;
      reset_n = 1'b1;
      check_en = 1'b1;

      // Watchdog from reset
      for (int i = 0; i < 15; i++) cyc();
      chk("hang_before_timeout", 64'(hang), 64'd0);
      cyc();
      chk("hang_at_timeout", 64'(hang), 64'd1);
      push(64'h100, 32'h13);
      cyc();
      wb_valid = 1'b0;
      chk("hang_sticky", 64'(hang), 64'd1);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      do_reset();

      // Fill without popping, then drain in order
      push(64'h8000_0000, 32'h13); cyc();
      chk("first_visible", 64'(out_valid), 64'd1);
      chk("first_pc", out_pc, 64'h8000_0000);
      chk("first_seq", out_seq, 64'd0);
      push(64'h8000_0004, 32'h13); cyc();
      push(64'h8000_0008, 32'h13); cyc();
      chk("instret3", instret, 64'd3);
      chk("head_held", out_pc, 64'h8000_0000);
      push(64'h8000_000c, 32'h13); cyc();
      chk("full_not_ready", 64'(wb_ready), 64'd0);
      push(64'hdead, 32'h13); cyc();
      chk("ignored_push", instret, 64'd4);
      wb_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_seq", out_seq, 64'(k));
         cyc();
         if (k == 0) chk("ready_after_pop", 64'(wb_ready), 64'd1);
      end
      chk("drained", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // Simultaneous push/pop stream
      push(64'h9000_0000, 32'h13); cyc();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         prev = out_seq;
         push(64'h9000_0004 + 64'(4 * i), 32'h13);
         cyc();
         chk("stream_seq", out_seq, prev + 64'd1);
      end
      wb_valid = 1'b0;
      cyc();
      out_ready = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         inst = $urandom;
         if (inst == INST_EBREAK) inst = inst ^ 32'h1;
         push({32'h8000_0000, $urandom}, inst);
         wb_valid = ($urandom_range(0, 9) < 6);
         out_ready = 1'($urandom);
         cyc();
      end

      // Reset with records queued
      wb_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      out_ready = 1'b0;
      push(64'h1000, 32'h13); cyc();
      push(64'h1004, 32'h13); cyc();
      wb_valid = 1'b0;
      chk("two_queued", 64'(out_valid), 64'd1);
      do_reset();
      push(64'h2000, 32'h13); cyc();
      wb_valid = 1'b0;
      chk("post_reset_seq", out_seq, 64'd0);

      // Ebreak halts intake but the queue still drains
      push(64'h8000_0010, INST_EBREAK);
      wb_wen = 1'b1; wb_skip = 1'b1;
      cyc();
      chk("halt_set", 64'(halt), 64'd1);
      chk("halt_not_ready", 64'(wb_ready), 64'd0);
      chk("ebreak_counted", instret, 64'd2);
      for (int i = 0; i < 3; i++) begin
         push(64'h3000 + 64'(i), 32'h13);
         cyc();
      end
      wb_valid = 1'b0;
      chk("halt_refuses", instret, 64'd2);
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && out_valid; i++) begin
         if (out_pc == 64'h8000_0010) begin
            found = 1'b1;
            chk("ebreak_inst", 64'(out_inst), 64'(INST_EBREAK));
            chk("ebreak_skip", 64'(out_skip), 64'd1);
            chk("ebreak_wen", 64'(out_wen), 64'd1);
         end
         cyc();
      end
      chk("ebreak_popped", 64'(found), 64'd1);
      chk("halt_drained", 64'(out_valid), 64'd0);
      chk("halt_sticky", 64'(halt), 64'd1);
      out_ready = 1'b0;
      cyc();

      check_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/commit_trace_queue.md
# commit_trace_queue

Sits between the writeback stage and the DPI register/PC trace bridge. Captures each retired instruction as a commit record into a small FIFO, tags it with a retire sequence number, and presents it to the trace consumer over a valid/ready handshake. It also detects `ebreak` to halt simulation and flags a hang when nothing retires for too long. This decouples pipeline retirement from DPI sampling so that difftest sees exactly one stable record per retired instruction.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of two ≥ 2.
- `TIMEOUT`, default 10000: idle cycles without a retire before `hang` asserts; must fit in 32 bits.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_valid`  in  1  writeback offers a retired instruction.
- `wb_ready`  out  1  queue accepts it (`!full && !halt`).
- `wb_pc`  in  64  PC of the retired instruction.
- `wb_inst`  in  32  instruction word.
- `wb_rd`  in  5  destination register.
- `wb_wen`  in  1  register write enable.
- `wb_wdata`  in  64  write-back data.
- `wb_skip`  in  1  difftest should skip the reference step (MMIO).
- `out_valid`  out  1  head record is valid.
- `out_ready`  in  1  consumer takes the head record.
- `out_pc`, `out_inst`, `out_rd`, `out_wen`, `out_wdata`, `out_skip`  out  64/32/5/1/64/1  head record fields.
- `out_seq`  out  64  retire sequence number of the head record.
- `instret`  out  64  count of accepted records.
- `halt`  out  1  sticky; an `ebreak` has been accepted.
- `hang`  out  1  sticky; watchdog has expired.

## Operation
- Push happens when `wb_valid && wb_ready`. The record is {pc, inst, rd, wen, wdata, skip, seq}, where seq is the current `instret`. `instret` then increments by 1 and wraps modulo 2^64.
- Pop happens when `out_valid && out_ready`. The head pointer advances.
- A push and a pop in the same cycle are both performed and the occupancy is unchanged. This is legal when full only if the push is actually accepted, and `wb_ready` is already low when full, so no push is accepted when full.
- `wb_rd == 0` is recorded with `wen` as given; the consumer ignores writes to x0.
- `wb_ready` is a function of registered state only: full flag and `halt`. There is no combinational path from `out_ready`.
- Ebreak: an accepted push with `wb_inst == 32'h0010_0073` sets `halt` on that edge. The ebreak record itself is queued. All later pushes are refused, and the FIFO continues to drain.
- Watchdog: a 32-bit idle counter clears on every accepted push and otherwise increments while `!halt`. When it reaches `TIMEOUT`, `hang` is set and the counter saturates. `hang` clears only on reset.
- Wrap-around: pointers are log2(DEPTH)+1 bits. Full is when the indices are equal and the MSBs differ; empty is when the pointers are equal.

## Timing
- Reset values: `out_valid`=0, `wb_ready`=1, `instret`=0, `halt`=0, `hang`=0, and all `out_*` data=0. Pointers and the idle counter are 0.
- Reset is asynchronous. If it is asserted mid-stream, queued records are discarded immediately and outputs return to their reset values without waiting for a clock edge.
- Latency: a record pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N. There is no same-cycle bypass.
- `out_*` fields are stable while `out_valid && !out_ready`.
- `halt` is high after the edge that accepts the ebreak, so `wb_ready` is low in the following cycle.
- `hang` rises after the edge where the idle count reaches `TIMEOUT`, i.e. `TIMEOUT` edges after the last accept or after reset.

## Structure
- Shared package `npc_trace_pkg` holds:
  - `commit_rec_t`, a packed struct with fields pc, inst, rd, wen, wdata, skip, seq;
  - `INST_EBREAK` = 32'h0010_0073.
- Sub-module `sync_fifo` is parameterised by width and depth and uses the same `clock`/`reset_n`. `commit_trace_queue` wraps it and adds the sequence tagging, ebreak detection and watchdog logic.

## Test plan
- Reset, then push 3 records (pc 0x8000_0000, 0x8000_0004, 0x8000_0008) with `out_ready`=0 -> `out_valid` goes high one cycle after the first push; the head stays at 0x8000_0000 with seq 0; `instret`=3.
- Push DEPTH=4 records without popping -> `wb_ready`=0 on the 5th cycle and a 5th `wb_valid` is ignored. Then set `out_ready`=1 -> records pop in order with seq 0,1,2,3, and `wb_ready` returns high after the first pop.
- Push and pop every cycle for 20 cycles -> occupancy stays at 1; `out_seq` increments by 1 each cycle with no gaps or duplicates.
- Push inst 0x0010_0073 at pc 0x8000_0010 -> `halt`=1 on the next cycle and `wb_ready`=0. The ebreak record still pops with skip and wen as given. Further `wb_valid` pulses are not counted in `instret`.
- With `TIMEOUT`=16, hold `wb_valid`=0 after reset -> `hang` rises after the 16th edge and stays high. A push afterwards leaves `hang`=1.
- Assert `reset_n`=0 for half a cycle with 2 records queued -> `out_valid`, `instret`, `halt` and `hang` drop to 0 immediately; after release the first push gets seq 0.
